// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - state enum and mode encodings shared by the DSP mode sequencer
package dsp_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ACCUM = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Z mux in bits [6:4], X/Y in bits [3:0]
  localparam logic [6:0] OPMODE_ZERO  = 7'b0000000;
  localparam logic [6:0] OPMODE_LOAD  = 7'b0000101;
  localparam logic [6:0] OPMODE_ACCUM = 7'b0100101;
  localparam logic [6:0] OPMODE_HOLD  = 7'b0100000;

  localparam logic [3:0] ALUMODE_ADD = 4'b0000;
  localparam logic [3:0] ALUMODE_SUB = 4'b0011;

  localparam logic [4:0] INMODE_DEFAULT     = 5'b00000;
  localparam logic [1:0] CARRYINSEL_DEFAULT = 2'b00;

endpackage

// File: rtl/dsp_mode_sequencer.sv
// rtl/dsp_mode_sequencer.sv - sequences opmode/ALU-mode words for a multiply-accumulate DSP slice
module dsp_mode_sequencer
  import dsp_pkg::*;
#(
  parameter int LEN_W        = 8,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             sub,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             sample_en,
  output logic [6:0]       OP_MODE,
  output logic [3:0]       ALU_MODE,
  output logic [4:0]       IN_MODE,
  output logic [1:0]       CARRYINSEL,
  output logic             CECTRL,
  output logic             CEALU_MODE,
  output logic             CEIN_MODE
);

  localparam logic [LEN_W-1:0] LEN_ZERO   = '0;
  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic             r_sub;
  logic             r_zero_first;
  logic [LEN_W-1:0] r_cnt;
  logic [3:0]       r_flush_cnt;

  logic             r_busy;
  logic             r_done;
  logic             r_sample_en;
  logic [6:0]       r_op_mode;
  logic [3:0]       r_alu_mode;
  logic             r_ce_ctrl;
  logic             r_ce_in;

  state_t           w_state_nxt;
  logic [LEN_W-1:0] w_len_nxt;
  logic             w_sub_nxt;
  logic             w_zero_first_nxt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [3:0]       w_flush_nxt;
  logic             w_aborted;

  logic             w_busy;
  logic             w_done;
  logic             w_sample_en;
  logic [6:0]       w_op_mode;
  logic [3:0]       w_alu_mode;
  logic             w_ce_ctrl;
  logic             w_ce_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_sub        <= 1'b0;
      r_zero_first <= 1'b0;
      r_cnt        <= '0;
      r_flush_cnt  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sample_en  <= 1'b0;
      r_op_mode    <= OPMODE_ZERO;
      r_alu_mode   <= ALUMODE_ADD;
      r_ce_ctrl    <= 1'b0;
      r_ce_in      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_sub        <= w_sub_nxt;
      r_zero_first <= w_zero_first_nxt;
      r_cnt        <= w_cnt_nxt;
      r_flush_cnt  <= w_flush_nxt;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_sample_en  <= w_sample_en;
      r_op_mode    <= w_op_mode;
      r_alu_mode   <= w_alu_mode;
      r_ce_ctrl    <= w_ce_ctrl;
      r_ce_in      <= w_ce_in;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_len_nxt        = r_len;
    w_sub_nxt        = r_sub;
    w_zero_first_nxt = r_zero_first;
    w_cnt_nxt        = r_cnt;
    w_flush_nxt      = r_flush_cnt;
    w_aborted        = 1'b0;

    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt      = S_IDLE;
      w_zero_first_nxt = 1'b0;
      w_aborted        = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            w_len_nxt = len;
            w_sub_nxt = sub;
            // A zero-length command spends two busy cycles in DONE; done fires on the second.
            if (len == LEN_ZERO) begin
              w_state_nxt      = S_DONE;
              w_zero_first_nxt = 1'b1;
            end else begin
              w_state_nxt = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          w_cnt_nxt = r_len - LEN_ONE;
          if (r_len > LEN_ONE) begin
            w_state_nxt = S_ACCUM;
          end else begin
            w_state_nxt = S_FLUSH;
            w_flush_nxt = FLUSH_LOAD;
          end
        end
        S_ACCUM: begin
          w_cnt_nxt = r_cnt - LEN_ONE;
          if (r_cnt == LEN_ONE) begin
            w_state_nxt = S_FLUSH;
            w_flush_nxt = FLUSH_LOAD;
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == 4'd0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_flush_nxt = r_flush_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (r_zero_first) begin
            w_zero_first_nxt = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they land in registers.
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_sample_en = 1'b0;
    w_op_mode   = OPMODE_HOLD;
    w_alu_mode  = ALUMODE_ADD;
    w_ce_ctrl   = 1'b0;
    w_ce_in     = 1'b0;

    case (w_state_nxt)
      S_IDLE: begin
        w_op_mode = w_aborted ? OPMODE_ZERO : OPMODE_HOLD;
      end
      S_LOAD: begin
        w_busy      = 1'b1;
        w_sample_en = 1'b1;
        w_op_mode   = OPMODE_LOAD;
        w_alu_mode  = w_sub_nxt ? ALUMODE_SUB : ALUMODE_ADD;
        w_ce_ctrl   = 1'b1;
        w_ce_in     = 1'b1;
      end
      S_ACCUM: begin
        w_busy      = 1'b1;
        w_sample_en = 1'b1;
        w_op_mode   = OPMODE_ACCUM;
        w_alu_mode  = w_sub_nxt ? ALUMODE_SUB : ALUMODE_ADD;
        w_ce_ctrl   = 1'b1;
      end
      S_FLUSH: begin
        w_busy     = 1'b1;
        w_op_mode  = OPMODE_HOLD;
        w_alu_mode = w_sub_nxt ? ALUMODE_SUB : ALUMODE_ADD;
        w_ce_ctrl  = 1'b1;
      end
      S_DONE: begin
        w_busy    = 1'b1;
        w_done    = !w_zero_first_nxt;
        w_op_mode = (w_len_nxt == LEN_ZERO) ? OPMODE_ZERO : OPMODE_HOLD;
        w_ce_ctrl = 1'b1;
      end
      default: begin
        w_op_mode = OPMODE_ZERO;
      end
    endcase
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign sample_en  = r_sample_en;
  assign OP_MODE    = r_op_mode;
  assign ALU_MODE   = r_alu_mode;
  assign IN_MODE    = INMODE_DEFAULT;
  assign CARRYINSEL = CARRYINSEL_DEFAULT;
  assign CECTRL     = r_ce_ctrl;
  assign CEALU_MODE = r_ce_ctrl;
  assign CEIN_MODE  = r_ce_in;

endmodule

// File: tb/tb_dsp_mode_sequencer.sv
// tb/tb_dsp_mode_sequencer.sv - randomized and directed bench for dsp_mode_sequencer against a schedule model
module tb_dsp_mode_sequencer;

  localparam int LEN_W = 8;
  localparam int FLUSH = 4;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [7:0] len   = 8'd0;
  logic       sub   = 1'b0;
  logic       abort = 1'b0;

  logic       busy, done, sample_en;
  logic [6:0] OP_MODE;
  logic [3:0] ALU_MODE;
  logic [4:0] IN_MODE;
  logic [1:0] CARRYINSEL;
  logic       CECTRL, CEALU_MODE, CEIN_MODE;

  always #5 clk = ~clk;

  dsp_mode_sequencer #(.LEN_W(LEN_W), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .sub(sub), .abort(abort),
    .busy(busy), .done(done), .sample_en(sample_en), .OP_MODE(OP_MODE),
    .ALU_MODE(ALU_MODE), .IN_MODE(IN_MODE), .CARRYINSEL(CARRYINSEL),
    .CECTRL(CECTRL), .CEALU_MODE(CEALU_MODE), .CEIN_MODE(CEIN_MODE)
  );

  logic [23:0] dut_vec;
  assign dut_vec = {busy, done, sample_en, OP_MODE, ALU_MODE, IN_MODE, CARRYINSEL,
                    CECTRL, CEALU_MODE, CEIN_MODE};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected outputs of one cycle: {busy, done, sample_en, opmode, alumode, inmode, carryinsel, ce x3}
  function automatic logic [23:0] mkv(input logic b, input logic d, input logic s,
                                      input logic [6:0] op, input logic [3:0] alu,
                                      input logic ce, input logic cein);
    return {b, d, s, op, alu, 5'b00000, 2'b00, ce, ce, cein};
  endfunction

  logic [23:0] sched[$];
  logic [23:0] exp_vec = '0;
  logic        cur_busy;
  assign cur_busy = exp_vec[23];

  function automatic void push_cmd(input int l, input logic s);
    logic [3:0] alu;
    alu = s ? 4'b0011 : 4'b0000;
    if (l == 0) begin
      sched.push_back(mkv(1'b1, 1'b0, 1'b0, 7'b0000000, 4'b0000, 1'b1, 1'b0));
      sched.push_back(mkv(1'b1, 1'b1, 1'b0, 7'b0000000, 4'b0000, 1'b1, 1'b0));
    end else begin
      sched.push_back(mkv(1'b1, 1'b0, 1'b1, 7'b0000101, alu, 1'b1, 1'b1));
      for (int i = 1; i < l; i++)
        sched.push_back(mkv(1'b1, 1'b0, 1'b1, 7'b0100101, alu, 1'b1, 1'b0));
      for (int i = 0; i < FLUSH; i++)
        sched.push_back(mkv(1'b1, 1'b0, 1'b0, 7'b0100000, alu, 1'b1, 1'b0));
      sched.push_back(mkv(1'b1, 1'b1, 1'b0, 7'b0100000, 4'b0000, 1'b1, 1'b0));
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sched.delete();
      exp_vec <= '0;
    end else if (cur_busy && abort) begin
      sched.delete();
      exp_vec <= mkv(1'b0, 1'b0, 1'b0, 7'b0000000, 4'b0000, 1'b0, 1'b0);
    end else if (sched.size() > 0) begin
      exp_vec <= sched.pop_front();
    end else if (!cur_busy && start && !abort) begin
      push_cmd(int'(len), sub);
      exp_vec <= sched.pop_front();
    end else begin
      exp_vec <= mkv(1'b0, 1'b0, 1'b0, 7'b0100000, 4'b0000, 1'b0, 1'b0);
    end
  end

  always @(negedge clk) check("cycle_outputs", 32'(dut_vec), 32'(exp_vec));

  logic [6:0] ops   [0:15];
  logic [3:0] alus  [0:15];
  logic       dones [0:15];

  task automatic issue(input int l, input logic s);
    @(posedge clk); #2;
    start = 1'b1; len = 8'(l); sub = s;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic observe(input int n, output int nb, output int nd, output int ns);
    nb = 0; nd = 0; ns = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      nb += int'(busy);
      nd += int'(done);
      ns += int'(sample_en);
      if (i < 16) begin
        ops[i]   = OP_MODE;
        alus[i]  = ALU_MODE;
        dones[i] = done;
      end
    end
  endtask

  logic [6:0]  exp_ops3 [0:7];
  logic [15:0] bpat;
  int nb, nd, ns, r;

  initial begin
    exp_ops3 = '{7'b0000101, 7'b0100101, 7'b0100101, 7'b0100000,
                 7'b0100000, 7'b0100000, 7'b0100000, 7'b0100000};
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(dut_vec), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("first_idle_op", 32'(OP_MODE), 32'h20);
    check("first_idle_busy", 32'(busy), 32'h0);

    issue(3, 1'b0);
    observe(10, nb, nd, ns);
    check("len3_busy", nb, 8);
    check("len3_done", nd, 1);
    check("len3_sample", ns, 3);
    check("len3_done_idx", 32'(dones[7]), 32'h1);
    for (int i = 0; i < 8; i++) check("len3_opmode", 32'(ops[i]), 32'(exp_ops3[i]));

    issue(1, 1'b1);
    observe(8, nb, nd, ns);
    check("len1_busy", nb, 6);
    check("len1_sample", ns, 1);
    check("len1_done", nd, 1);
    check("len1_alu_load", 32'(alus[0]), 32'h3);
    check("len1_alu_flush", 32'(alus[1]), 32'h3);
    check("len1_no_accum", 32'(ops[1]), 32'h20);

    issue(0, 1'b0);
    observe(4, nb, nd, ns);
    check("len0_busy", nb, 2);
    check("len0_done", nd, 1);
    check("len0_sample", ns, 0);
    check("len0_done_op", 32'(ops[1]), 32'h0);

    issue(5, 1'b0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_op", 32'(OP_MODE), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    issue(2, 1'b0);
    observe(9, nb, nd, ns);
    check("after_abort_busy", nb, 7);
    check("after_abort_done", nd, 1);

    @(posedge clk); #2;
    start = 1'b1; abort = 1'b1; len = 8'd3;
    @(posedge clk); #2;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_beats_start", 32'(busy), 32'h0);

    @(posedge clk); #2;
    len = 8'd2; sub = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bpat[i] = busy;
      if (i == 14) start = 1'b0;
    end
    check("held_start_busy_pattern", 32'(bpat), 32'h7F7F);
    repeat (4) @(posedge clk);

    issue(255, 1'b1);
    observe(262, nb, nd, ns);
    check("len255_busy", nb, 260);
    check("len255_sample", ns, 255);
    check("len255_done", nd, 1);

    issue(1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("async_reset_flush", 32'(dut_vec), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    observe(6, nb, nd, ns);
    check("reset_no_done", nd, 0);

    repeat (400) begin
      @(posedge clk); #2;
      r     = int'($urandom_range(0, 9));
      start = ($urandom_range(0, 3) == 0);
      len   = (r == 0) ? 8'd0 : (r == 1) ? 8'($urandom_range(10, 40)) : 8'($urandom_range(1, 6));
      sub   = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #2;
    start = 1'b0; abort = 1'b0;
    repeat (60) @(posedge clk);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_mode_sequencer.md
DSP_MODE_SEQUENCER -- requirements
Module: dsp_mode_sequencer

Interface
REQ-001 Parameter LEN_W, default 8: width of the product-count field.
REQ-002 Parameter FLUSH_CYCLES, default 4: hold cycles needed to drain the downstream DSP pipeline; legal range 1..15.
REQ-003 clk  input  1  single clock; every register updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  command request; sampled only in IDLE.
REQ-006 len  input  LEN_W  number of products to accumulate; captured with start.
REQ-007 sub  input  1  1 = subtract-accumulate, 0 = add-accumulate; captured with start.
REQ-008 abort  input  1  synchronous cancel of the running command.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 sample_en  output  1  operand-advance strobe for the A/B source.
REQ-012 OP_MODE  output  7  opmode for the downstream modes stage.
REQ-013 ALU_MODE  output  4  ALU mode for the downstream modes stage.
REQ-014 IN_MODE  output  5  in-mode; constant 5'b00000.
REQ-015 CARRYINSEL  output  2  carry-in select; constant 2'b00.
REQ-016 CECTRL, CEALU_MODE, CEIN_MODE  output  1 each  clock enables for the downstream mode registers.

Function
REQ-017 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-018 The FSM SHALL have exactly five states: IDLE, LOAD, ACCUM, FLUSH, DONE.
REQ-019 In IDLE, start=1 SHALL capture len and sub and move to LOAD; if the captured len is 0, the FSM SHALL move to DONE instead.
REQ-020 LOAD SHALL last 1 cycle: OP_MODE=7'b0000101 (Z=0, X/Y=M) and sample_en=1.
REQ-021 LOAD SHALL move to ACCUM if len>1, otherwise to FLUSH.
REQ-022 ACCUM SHALL last exactly len-1 cycles: OP_MODE=7'b0100101 (Z=P, X/Y=M) and sample_en=1.
REQ-023 ACCUM SHALL be timed by a down-counter of LEN_W bits with no wrap; the counter SHALL be loaded in LOAD and the FSM SHALL exit on count 1.
REQ-024 FLUSH SHALL last exactly FLUSH_CYCLES cycles: OP_MODE=7'b0100000 (hold P) and sample_en=0.
REQ-025 DONE SHALL last 1 cycle: done=1, with OP_MODE=7'b0100000 after a nonzero len and 7'b0000000 after len=0; the FSM SHALL then return to IDLE.
REQ-026 In IDLE, OP_MODE SHALL be 7'b0100000.
REQ-027 ALU_MODE SHALL be 4'b0011 in LOAD, ACCUM and FLUSH when the captured sub=1, and 4'b0000 otherwise.
REQ-028 CECTRL and CEALU_MODE SHALL be 1 in LOAD, ACCUM, FLUSH and DONE, and 0 in IDLE.
REQ-029 CEIN_MODE SHALL be 1 only in LOAD.
REQ-030 Latency: start accepted at edge t SHALL give LOAD outputs from cycle t+1; busy SHALL be high for exactly len+FLUSH_CYCLES+1 cycles (2 cycles for len=0).
REQ-031 start while busy SHALL be ignored, with no queuing.
REQ-032 start asserted in the DONE cycle SHALL be ignored; a new command SHALL be accepted only from IDLE.
REQ-033 abort=1 in any non-IDLE state SHALL force IDLE on the next edge: OP_MODE=7'b0000000 for that one cycle, no done pulse, sample_en=0.
REQ-034 abort takes priority over start.
REQ-035 abort in IDLE SHALL have no effect.
REQ-036 len equal to all-ones SHALL be legal: ACCUM runs 2^LEN_W-2 cycles.

Reset
REQ-037 While rst=0: state=IDLE, counter=0, captured len/sub=0, busy=done=sample_en=0, OP_MODE=7'b0000000, ALU_MODE=0, IN_MODE=0, CARRYINSEL=0, all CE outputs=0.
REQ-038 Reset asserted mid-command SHALL abandon the command immediately, with no done pulse.
REQ-039 The first cycle after reset release SHALL be IDLE.

Structure
REQ-040 The opmode/ALU-mode encodings and the state enum SHALL be defined in shared package dsp_pkg.
REQ-041 The block SHALL be a single module with no sub-modules; the counter is inline.

Verification
REQ-042 len=3, sub=0, FLUSH_CYCLES=4 -> OP_MODE sequence 0000101, 0100101, 0100101, then 0100000 x4; done one cycle later; busy for 8 cycles.
REQ-043 len=1, sub=1 -> LOAD then FLUSH with ALU_MODE=0011; no ACCUM; sample_en high for exactly 1 cycle.
REQ-044 len=0 -> busy for 2 cycles, done pulse, OP_MODE=0000000 in DONE, sample_en never high.
REQ-045 len=5, abort in the 2nd ACCUM cycle -> next cycle IDLE, OP_MODE=0000000, done never asserted; a following start is accepted normally.
REQ-046 start held high for the whole of a len=2 command -> exactly one command executes, then a second begins only after the IDLE cycle.
REQ-047 rst=0 during FLUSH -> all outputs take reset values asynchronously, before the next clock edge.
